fetch_decode_ctrl: RTL and testbench

FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

---
 rtl/fetch_decode_ctrl_pkg.sv | 31 +++
 rtl/fetch_decode_ctrl_instr_decoder.sv | 38 +++
 rtl/fetch_decode_ctrl.sv | 141 ++++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared definitions for the fetch/decode sequencer: FSM states, opcode
// constants and instruction-word field positions.
package fetch_decode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcodes 3'b000..3'b101 are ALU operations.
    localparam logic [2:0] OP_ALU_FIRST = 3'b000;
    localparam logic [2:0] OP_ALU_LAST  = 3'b101;
    localparam logic [2:0] OP_HALT      = 3'b110;
    localparam logic [2:0] OP_LDST      = 3'b111;

    // Instruction word field positions.
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 13;
    localparam int unsigned RS_MSB  = 12;
    localparam int unsigned RS_LSB  = 10;
    localparam int unsigned RT_MSB  = 9;
    localparam int unsigned RT_LSB  = 7;
    localparam int unsigned RD_MSB  = 6;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned LS_BIT  = 3;   // 0 = load, 1 = store

endpackage

// File: rtl/fetch_decode_ctrl_instr_decoder.sv
// Combinational instruction decoder: splits the IR into register selects and
// opcode, and classifies the instruction.
module instr_decoder
    import fetch_decode_ctrl_pkg::*;
#(
    parameter logic [2:0] HALT_OP = OP_HALT
) (
    input  logic [15:0] i_ir,
    output logic [2:0]  o_op,
    output logic [2:0]  o_rs,
    output logic [2:0]  o_rt,
    output logic [2:0]  o_rd,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic        o_is_halt,
    output logic        o_is_alu
);

    logic w_is_ldst;
    logic w_unused_bits;

    // Field extraction and instruction classification.
    always_comb begin
        o_op       = i_ir[OPC_MSB:OPC_LSB];
        o_rs       = i_ir[RS_MSB:RS_LSB];
        o_rt       = i_ir[RT_MSB:RT_LSB];
        o_rd       = i_ir[RD_MSB:RD_LSB];
        o_is_halt  = (o_op == HALT_OP);
        w_is_ldst  = (o_op == OP_LDST) && !o_is_halt;
        o_is_load  = w_is_ldst && !i_ir[LS_BIT];
        o_is_store = w_is_ldst &&  i_ir[LS_BIT];
        o_is_alu   = !w_is_ldst && !o_is_halt;
    end

    // Low IR bits carry no meaning for this sequencer.
    assign w_unused_bits = ^i_ir[2:0];

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode sequencer: fetches an instruction word, decodes it,
// and steps through EXEC / MEM / WB, or parks in HALT.
module fetch_decode_ctrl
    import fetch_decode_ctrl_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter logic [2:0] HALT_OP  = 3'b110
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [2:0]  alu_op,
    output logic [2:0]  rs_sel,
    output logic [2:0]  rt_sel,
    output logic [2:0]  rd_sel,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        halted
);

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic        r_imem_req;
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_halted;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_halt;
    logic        w_is_alu;

    instr_decoder #(
        .HALT_OP (HALT_OP)
    ) u_decoder (
        .i_ir       (r_ir),
        .o_op       (alu_op),
        .o_rs       (rs_sel),
        .o_rt       (rt_sel),
        .o_rd       (rd_sel),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store),
        .o_is_halt  (w_is_halt),
        .o_is_alu   (w_is_alu)
    );

    // Sequencer FSM; outputs are registered and set on entry to each state.
    // In FETCH with imem_req low (only right after reset) the first edge just
    // raises the request, so an ack is never taken without a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= PC_RESET;
            r_ir         <= '0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_pc       <= r_pc + 8'd1;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_is_alu) begin
                        r_reg_write  <= 1'b1;
                        r_mem_to_reg <= 1'b0;
                        r_state      <= ST_WB;
                    end else begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_is_store;
                        r_state      <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (r_dmem_req && dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (w_is_load) begin
                            r_reg_write  <= 1'b1;
                            r_mem_to_reg <= 1'b1;
                            r_state      <= ST_WB;
                        end else begin
                            r_imem_req   <= 1'b1;
                            r_state      <= ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    r_mem_to_reg <= 1'b0;
                    r_imem_req   <= 1'b1;
                    r_state      <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_imem_req <= 1'b0;
                    r_dmem_req <= 1'b0;
                    r_state    <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign reg_write  = r_reg_write;
    assign mem_to_reg = r_mem_to_reg;
    assign halted     = r_halted;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: a cycle-by-cycle vector table on the
// default instance plus hand-written sequences for reset-in-MEM and PC wrap
// into HALT on a second instance with PC_RESET = 8'hFF.
module tb_fetch_decode_ctrl;

    logic clk;
    int   n_checks;
    int   n_errors;
    logic mon_on;

    // Instance A: default parameters.
    logic        rst_a, iack_a, dack_a;
    logic [15:0] rdata_a;
    logic        ireq_a, rw_a, m2r_a, dreq_a, dwe_a, halt_a;
    logic [7:0]  iaddr_a;
    logic [2:0]  op_a, rs_a, rt_a, rd_a;

    // Instance B: PC_RESET = 8'hFF.
    logic        rst_b, iack_b, dack_b;
    logic [15:0] rdata_b;
    logic        ireq_b, rw_b, m2r_b, dreq_b, dwe_b, halt_b;
    logic [7:0]  iaddr_b;
    logic [2:0]  op_b, rs_b, rt_b, rd_b;

    fetch_decode_ctrl u_dut_a (
        .clk(clk), .rst(rst_a),
        .imem_req(ireq_a), .imem_addr(iaddr_a), .imem_ack(iack_a), .imem_rdata(rdata_a),
        .alu_op(op_a), .rs_sel(rs_a), .rt_sel(rt_a), .rd_sel(rd_a),
        .reg_write(rw_a), .mem_to_reg(m2r_a),
        .dmem_req(dreq_a), .dmem_we(dwe_a), .dmem_ack(dack_a), .halted(halt_a)
    );

    fetch_decode_ctrl #(
        .PC_RESET (8'hFF),
        .HALT_OP  (3'b110)
    ) u_dut_b (
        .clk(clk), .rst(rst_b),
        .imem_req(ireq_b), .imem_addr(iaddr_b), .imem_ack(iack_b), .imem_rdata(rdata_b),
        .alu_op(op_b), .rs_sel(rs_b), .rt_sel(rt_b), .rd_sel(rd_b),
        .reg_write(rw_b), .mem_to_reg(m2r_b),
        .dmem_req(dreq_b), .dmem_we(dwe_b), .dmem_ack(dack_b), .halted(halt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        iack;
        logic [15:0] rdata;
        logic        dack;
        logic        ireq;
        logic [7:0]  iaddr;
        logic        rw;
        logic        m2r;
        logic        dreq;
        logic        dwe;
        logic        halt;
        logic [2:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst, input logic iack, input logic [15:0] rdata, input logic dack,
        input logic ireq, input logic [7:0] iaddr, input logic rw, input logic m2r,
        input logic dreq, input logic dwe, input logic halt,
        input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        vec_t v;
        v.rst = rst; v.iack = iack; v.rdata = rdata; v.dack = dack;
        v.ireq = ireq; v.iaddr = iaddr; v.rw = rw; v.m2r = m2r;
        v.dreq = dreq; v.dwe = dwe; v.halt = halt;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The two memory requests of an instance must never overlap.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("excl_a", 16'(ireq_a & dreq_a), 16'h0);
            chk("excl_b", 16'(ireq_b & dreq_b), 16'h0);
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_on   = 1'b0;
        rst_a = 1'b1; iack_a = 1'b0; dack_a = 1'b0; rdata_a = '0;
        rst_b = 1'b1; iack_b = 1'b0; dack_b = 1'b0; rdata_b = '0;

        //          rst iack rdata   dack ireq addr  rw m2r dreq dwe hlt  op    rs    rt    rd
        // reset, then ALU op 0560 acked after two wait cycles
        vq.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 3'd0));
        vq.push_back(mk(0, 1, 16'h0560, 0, 0, 8'h01, 0, 0, 0, 0, 0, 3'd0, 3'd1, 3'd2, 3'd6)); // DECODE
        vq.push_back(mk(0, 1, 16'hFFFF, 1, 0, 8'h01, 0, 0, 0, 0, 0, 3'd0, 3'd1, 3'd2, 3'd6)); // EXEC, spurious acks
        vq.push_back(mk(0, 1, 16'hFFFF, 1, 0, 8'h01, 1, 0, 0, 0, 0, 3'd0, 3'd1, 3'd2, 3'd6)); // WB
        vq.push_back(mk(0, 1, 16'hFFFF, 1, 1, 8'h01, 0, 0, 0, 0, 0, 3'd0, 3'd1, 3'd2, 3'd6)); // FETCH
        // load E400, immediate fetch ack, three MEM wait cycles
        vq.push_back(mk(0, 1, 16'hE400, 0, 0, 8'h02, 0, 0, 0, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // DECODE
        vq.push_back(mk(0, 1, 16'hFFFF, 1, 0, 8'h02, 0, 0, 0, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // EXEC
        vq.push_back(mk(0, 1, 16'hFFFF, 1, 0, 8'h02, 0, 0, 1, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // MEM
        vq.push_back(mk(0, 1, 16'hFFFF, 0, 0, 8'h02, 0, 0, 1, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h02, 0, 0, 1, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h02, 0, 0, 1, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0));
        vq.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h02, 1, 1, 0, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // WB
        vq.push_back(mk(0, 0, 16'h0000, 1, 1, 8'h02, 0, 0, 0, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // FETCH
        // store E408, one MEM wait cycle, returns straight to FETCH
        vq.push_back(mk(0, 1, 16'hE408, 0, 0, 8'h03, 0, 0, 0, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // DECODE
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h03, 0, 0, 0, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // EXEC
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h03, 0, 0, 1, 1, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // MEM
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h03, 0, 0, 1, 1, 0, 3'd7, 3'd1, 3'd0, 3'd0));
        vq.push_back(mk(0, 0, 16'h0000, 1, 1, 8'h03, 0, 0, 0, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0)); // FETCH
        vq.push_back(mk(0, 0, 16'h0000, 1, 1, 8'h03, 0, 0, 0, 0, 0, 3'd7, 3'd1, 3'd0, 3'd0));

        #1;
        chk("rst_async_ireq", 16'(ireq_a), 16'h0);
        chk("rst_async_addr", 16'(iaddr_a), 16'h0000);
        mon_on = 1'b1;

        foreach (vq[i]) begin
            rst_a   = vq[i].rst;
            iack_a  = vq[i].iack;
            rdata_a = vq[i].rdata;
            dack_a  = vq[i].dack;
            step();
            chk($sformatf("v%0d_imem_req", i),   16'(ireq_a),  16'(vq[i].ireq));
            chk($sformatf("v%0d_imem_addr", i),  16'(iaddr_a), 16'(vq[i].iaddr));
            chk($sformatf("v%0d_reg_write", i),  16'(rw_a),    16'(vq[i].rw));
            chk($sformatf("v%0d_mem_to_reg", i), 16'(m2r_a),   16'(vq[i].m2r));
            chk($sformatf("v%0d_dmem_req", i),   16'(dreq_a),  16'(vq[i].dreq));
            chk($sformatf("v%0d_dmem_we", i),    16'(dwe_a),   16'(vq[i].dwe));
            chk($sformatf("v%0d_halted", i),     16'(halt_a),  16'(vq[i].halt));
            chk($sformatf("v%0d_alu_op", i),     16'(op_a),    16'(vq[i].op));
            chk($sformatf("v%0d_rs_sel", i),     16'(rs_a),    16'(vq[i].rs));
            chk($sformatf("v%0d_rt_sel", i),     16'(rt_a),    16'(vq[i].rt));
            chk($sformatf("v%0d_rd_sel", i),     16'(rd_a),    16'(vq[i].rd));
        end

        // Reset asserted mid-MEM: requests drop before the next edge.
        iack_a = 1'b1; rdata_a = 16'hE400; dack_a = 1'b0;
        step();                                   // DECODE
        iack_a = 1'b0; rdata_a = '0;
        step();                                   // EXEC
        step();                                   // MEM
        chk("mid_mem_dreq_before", 16'(dreq_a), 16'h1);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("mid_mem_dreq_async", 16'(dreq_a), 16'h0);
        chk("mid_mem_ireq_async", 16'(ireq_a), 16'h0);
        chk("mid_mem_addr_async", 16'(iaddr_a), 16'h0000);
        chk("mid_mem_rs_async", 16'(rs_a), 16'h0);
        step();
        rst_a = 1'b0;
        step();
        chk("post_rst_ireq", 16'(ireq_a), 16'h1);
        chk("post_rst_addr", 16'(iaddr_a), 16'h0000);
        chk("post_rst_dreq", 16'(dreq_a), 16'h0);

        // Instance B: PC wraps FF -> 00, then HALT is absorbing.
        chk("b_rst_addr", 16'(iaddr_b), 16'h00FF);
        rst_b = 1'b0;
        step();
        chk("b_fetch_ireq", 16'(ireq_b), 16'h1);
        chk("b_fetch_addr", 16'(iaddr_b), 16'h00FF);
        iack_b = 1'b1; rdata_b = 16'h0560;
        step();                                   // DECODE
        iack_b = 1'b0; rdata_b = '0;
        chk("b_wrap_addr", 16'(iaddr_b), 16'h0000);
        step();                                   // EXEC
        step();                                   // WB
        chk("b_wb_reg_write", 16'(rw_b), 16'h1);
        step();                                   // FETCH
        chk("b_fetch2_ireq", 16'(ireq_b), 16'h1);
        chk("b_fetch2_addr", 16'(iaddr_b), 16'h0000);
        iack_b = 1'b1; rdata_b = 16'hC000;
        step();                                   // DECODE
        chk("b_halt_op", 16'(op_b), 16'h6);
        chk("b_decode_halted", 16'(halt_b), 16'h0);
        step();                                   // HALT
        for (int unsigned k = 0; k < 20; k++) begin
            iack_b = k[0];
            dack_b = ~k[0];
            rdata_b = 16'h0560;
            chk($sformatf("b_halt%0d_halted", k), 16'(halt_b), 16'h1);
            chk($sformatf("b_halt%0d_ireq", k),   16'(ireq_b), 16'h0);
            chk($sformatf("b_halt%0d_dreq", k),   16'(dreq_b), 16'h0);
            chk($sformatf("b_halt%0d_rw", k),     16'(rw_b),   16'h0);
            chk($sformatf("b_halt%0d_addr", k),   16'(iaddr_b), 16'h0001);
            step();
        end

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
